// File: rtl/regfile_wport_arb.sv
// Write-port arbiter: shares one register-file write port between the writeback
// stage (A) and a 2-entry FIFO of multi-cycle unit writes (B) with starvation guard and squash.
module regfile_wport_arb #(
  parameter int unsigned ASIZE        = 4,
  parameter int unsigned DSIZE        = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [ASIZE-1:0] a_waddr,
  input  logic [DSIZE-1:0] a_wdata,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [ASIZE-1:0] b_waddr,
  input  logic [DSIZE-1:0] b_wdata,
  output logic             b_ready,
  output logic             rf_wen,
  output logic [ASIZE-1:0] rf_waddr,
  output logic [DSIZE-1:0] rf_wdata,
  output logic [1:0]       b_count
);

  typedef enum logic {StNormal, StForce} state_e;

  state_e           state_q, state_d;
  logic [ASIZE-1:0] addr_q  [2];
  logic [ASIZE-1:0] addr_d  [2];
  logic [DSIZE-1:0] data_q  [2];
  logic [DSIZE-1:0] data_d  [2];
  logic [1:0]       stale_q, stale_d;
  logic [1:0]       count_q, count_d;
  logic [2:0]       cnt_q, cnt_d;

  logic       head_v, head_live, force_st;
  logic       grant_a, grant_b, pop, push, starved;
  logic [1:0] n_after_pop;

  always_comb begin
    head_v    = (count_q != 2'd0);
    head_live = head_v & ~stale_q[0];
    force_st  = (state_q == StForce);

    a_ready = ~rst & ~force_st;
    b_ready = ~rst & (count_q != 2'd2);
    b_count = rst ? 2'd0 : count_q;

    grant_a = a_valid & a_ready;
    grant_b = ~rst & head_live & (force_st | ~a_valid);

    rf_wen   = grant_a | grant_b;
    rf_waddr = grant_a ? a_waddr : addr_q[0];
    rf_wdata = grant_a ? a_wdata : data_q[0];

    // A stale head leaves without a write, so A keeps the port that cycle.
    pop     = head_v & (grant_b | stale_q[0]);
    push    = b_valid & b_ready;
    starved = head_live & ~grant_b;
  end

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    stale_d     = stale_q;
    n_after_pop = count_q;

    if (pop) begin
      addr_d[0]   = addr_q[1];
      data_d[0]   = data_q[1];
      stale_d[0]  = stale_q[1];
      n_after_pop = count_q - 2'd1;
    end
    if (push) begin
      addr_d[n_after_pop[0]]  = b_waddr;
      data_d[n_after_pop[0]]  = b_wdata;
      stale_d[n_after_pop[0]] = 1'b0;
    end
    count_d = n_after_pop + {1'b0, push};

    // A is younger than everything queued, including a same-cycle push.
    if (grant_a) begin
      for (int i = 0; i < 2; i++) begin
        if (addr_d[i] == a_waddr) stale_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;

    if (!head_v || pop) begin
      cnt_d = 3'd0;
    end else if (starved) begin
      cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
    end

    unique case (state_q)
      StNormal: begin
        if (starved && (32'(cnt_q) + 32'd1 >= STARVE_LIMIT)) state_d = StForce;
      end
      StForce: begin
        if (pop) state_d = StNormal;
      end
      default: state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StNormal;
      stale_q <= 2'b00;
      count_q <= 2'd0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: per-cycle vector table plus a queue of expected B writes.
module tb_regfile_wport_arb;

  localparam int unsigned SL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [3:0]  a_waddr, b_waddr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ready, b_ready, rf_wen;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [1:0]  b_count;

  always #5 clk = ~clk;

  regfile_wport_arb #(
    .ASIZE       (4),
    .DSIZE       (16),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_waddr (a_waddr),
    .a_wdata (a_wdata),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_waddr (b_waddr),
    .b_wdata (b_wdata),
    .b_ready (b_ready),
    .rf_wen  (rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .b_count (b_count)
  );

  typedef struct {
    logic        r;
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [15:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_wen;
    logic [3:0]  e_wa;
    logic [15:0] e_wd;
    logic [1:0]  e_cnt;
  } vec_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  qb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void add(logic r, logic av, logic [3:0] aa, logic [15:0] ad,
                              logic bv, logic [3:0] ba, logic [15:0] bd,
                              logic ear, logic ebr, logic ewen, logic [3:0] ewa,
                              logic [15:0] ewd, logic [1:0] ecnt);
    vec_t v;
    v.r = r; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.e_ar = ear; v.e_br = ebr; v.e_wen = ewen; v.e_wa = ewa; v.e_wd = ewd; v.e_cnt = ecnt;
    vecs.push_back(v);
  endfunction

  // Pop the expected B write and compare it with what the port is driving.
  task automatic check_b_write(string name);
    wr_t w;
    if (qb.size() == 0) begin
      chk({name, "_unexpected_b"}, 32'(rf_wen), 32'd0);
    end else begin
      w = qb.pop_front();
      chk({name, "_b_waddr"}, 32'(rf_waddr), 32'(w.a));
      chk({name, "_b_wdata"}, 32'(rf_wdata), 32'(w.d));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    rst = v.r; a_valid = v.av; a_waddr = v.aa; a_wdata = v.ad;
    b_valid = v.bv; b_waddr = v.ba; b_wdata = v.bd;
    @(negedge clk);
    chk({nm, "_a_ready"}, 32'(a_ready), 32'(v.e_ar));
    chk({nm, "_b_ready"}, 32'(b_ready), 32'(v.e_br));
    chk({nm, "_rf_wen"}, 32'(rf_wen), 32'(v.e_wen));
    chk({nm, "_b_count"}, 32'(b_count), 32'(v.e_cnt));
    if (v.e_wen) begin
      chk({nm, "_rf_waddr"}, 32'(rf_waddr), 32'(v.e_wa));
      chk({nm, "_rf_wdata"}, 32'(rf_wdata), 32'(v.e_wd));
    end
    if (v.r) begin
      qb.delete();
    end else begin
      if (rf_wen && !(v.av && v.e_ar)) check_b_write(nm);
      if (v.bv && v.e_br) qb.push_back({v.ba, v.bd});
      if (v.av && v.e_ar) begin
        for (int k = qb.size() - 1; k >= 0; k--) begin
          if (qb[k].a == v.aa) qb.delete(k);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    bit got;

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_waddr = '0; a_wdata = '0; b_waddr = '0; b_wdata = '0;

    //  r  av aa  ad        bv ba  bd        ar br wen wa  wd        cnt
    add(1, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 0, 0,  0,  16'h0000, 0);
    add(1, 1, 3,  16'h9999, 1, 3,  16'h9999, 0, 0, 0,  0,  16'h0000, 0);
    // A only
    add(0, 1, 3,  16'h0042, 0, 0,  16'h0000, 1, 1, 1,  3,  16'h0042, 0);
    // B only
    add(0, 0, 0,  16'h0000, 1, 5,  16'h1111, 1, 1, 0,  0,  16'h0000, 0);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 1,  5,  16'h1111, 1);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 0);
    // Starvation: three A grants then the forced B write
    add(0, 1, 1,  16'h0101, 1, 7,  16'hBEEF, 1, 1, 1,  1,  16'h0101, 0);
    add(0, 1, 1,  16'h0102, 0, 0,  16'h0000, 1, 1, 1,  1,  16'h0102, 1);
    add(0, 1, 1,  16'h0103, 0, 0,  16'h0000, 1, 1, 1,  1,  16'h0103, 1);
    add(0, 1, 1,  16'h0104, 0, 0,  16'h0000, 1, 1, 1,  1,  16'h0104, 1);
    add(0, 1, 1,  16'h0105, 0, 0,  16'h0000, 0, 1, 1,  7,  16'hBEEF, 1);
    add(0, 1, 1,  16'h0105, 0, 0,  16'h0000, 1, 1, 1,  1,  16'h0105, 0);
    // Squash
    add(0, 0, 0,  16'h0000, 1, 2,  16'hAAAA, 1, 1, 0,  0,  16'h0000, 0);
    add(0, 1, 2,  16'h5555, 0, 0,  16'h0000, 1, 1, 1,  2,  16'h5555, 1);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 1);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 0);
    // Full / back-pressure
    add(0, 1, 6,  16'h0600, 1, 1,  16'h0001, 1, 1, 1,  6,  16'h0600, 0);
    add(0, 1, 6,  16'h0601, 1, 4,  16'h0004, 1, 1, 1,  6,  16'h0601, 1);
    add(0, 1, 6,  16'h0602, 1, 9,  16'h0009, 1, 0, 1,  6,  16'h0602, 2);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 0, 1,  1,  16'h0001, 2);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 1,  4,  16'h0004, 1);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 0);
    // Reset while full and in the forced state
    add(0, 1, 8,  16'h0800, 1, 10, 16'h000A, 1, 1, 1,  8,  16'h0800, 0);
    add(0, 1, 8,  16'h0801, 1, 11, 16'h000B, 1, 1, 1,  8,  16'h0801, 1);
    add(0, 1, 8,  16'h0802, 0, 0,  16'h0000, 1, 0, 1,  8,  16'h0802, 2);
    add(0, 1, 8,  16'h0803, 0, 0,  16'h0000, 1, 0, 1,  8,  16'h0803, 2);
    add(1, 1, 8,  16'h0804, 1, 12, 16'h000C, 0, 0, 0,  0,  16'h0000, 0);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 0);
    add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 1, 1, 0,  0,  16'h0000, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Worst-case wait: B reaches the head and is written after SL+1 cycles of A pressure.
    rst = 1'b0;
    a_valid = 1'b1; a_waddr = 4'd13; a_wdata = 16'hD000;
    b_valid = 1'b1; b_waddr = 4'd12; b_wdata = 16'h0C0C;
    qb.push_back({4'd12, 16'h0C0C});
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    waited = 0;
    got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      a_wdata = 16'hD000 + 16'(c);
      @(negedge clk);
      if (rf_wen && !a_ready) begin
        got = 1'b1;
        waited = c;
        check_b_write("starve_seq");
      end
      @(posedge clk);
      #1;
    end
    chk("starve_wait_cycles", 32'(waited), 32'(SL + 1));
    @(negedge clk);
    chk("starve_release_a_ready", 32'(a_ready), 32'd1);
    chk("starve_release_a_write", 32'(rf_waddr), 32'd13);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("final_b_count", 32'(b_count), 32'd0);
    chk("final_rf_wen", 32'(rf_wen), 32'd0);
    chk("scoreboard_drained", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arb.md
# regfile_wport_arb

Write-port arbiter for the single-write-port register file. It shares the one write port between two requesters. Port A is the pipeline writeback stage: single-cycle, normally highest priority. Port B is a multi-cycle unit (load/multiply), buffered in a 2-entry FIFO. The arbiter drives the register file's wen/waddr/wdata directly, adds a starvation guard for B, and squashes B writes made obsolete by younger A writes.

## Interface
Parameters:
- ASIZE, 4, register address width
- DSIZE, 16, register data width
- STARVE_LIMIT, 3, consecutive cycles a non-stale FIFO head may be denied before B is forced (legal 1..7)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  writeback stage has a write this cycle
- a_waddr  input  ASIZE  A destination register
- a_wdata  input  DSIZE  A write data
- a_ready  output  1  A write accepted this cycle; low = pipeline must stall
- b_valid  input  1  multi-cycle unit offers a write
- b_waddr  input  ASIZE  B destination register
- b_wdata  input  DSIZE  B write data
- b_ready  output  1  FIFO can accept; push on b_valid & b_ready
- rf_wen  output  1  to register file wen
- rf_waddr  output  ASIZE  to register file waddr
- rf_wdata  output  DSIZE  to register file wdata
- b_count  output  2  FIFO occupancy, 0..2

## Operation
- **State.** 2-entry FIFO; each entry holds {addr, data, stale}. Also a starvation counter `cnt` (3 bits, saturating) and FSM `state` ∈ {NORMAL, FORCE}.
- **Grant, combinational from current state and inputs. Priority order:**
  1. `state`==FORCE and head valid, not stale: grant head; a_ready=0.
  2. Else if a_valid: grant A; a_ready=1.
  3. Else if head valid, not stale: grant head.
  4. Else no grant; rf_wen=0.
- **a_ready.** 1 whenever `state`==NORMAL, regardless of a_valid. 0 in FORCE.
- **Write port drive.**
  - Grant A: rf_wen=1, rf_waddr=a_waddr, rf_wdata=a_wdata.
  - Grant head: rf_wen=1, head addr/data.
  - No grant: rf_wen=0; rf_waddr/rf_wdata don't-care (drive head fields).
- **Pop.** The head pops at posedge if it is granted, or if it is stale. A stale head is discarded without a register-file write, and the grant that cycle is still free for A.
- **Push.** On b_valid & b_ready, the B write is written behind the current tail, after the pop.
- **b_ready.** b_ready = (b_count < 2). It is based on the registered count, so there is no same-cycle pop-then-push credit.
- **Squash rule.** A is always younger than every B write in flight. When A is granted, every FIFO entry with addr == a_waddr gets stale=1, including an entry being pushed that same cycle.
- **Starvation counter.**
  - `cnt` resets to 0 when the FIFO is empty, or when the head pops.
  - Otherwise `cnt` increments when a non-stale head is denied.
- **FSM transitions.**
  - NORMAL → FORCE at posedge when `cnt`+1 would reach STARVE_LIMIT.
  - FORCE → NORMAL at posedge when the head pops.
  - FORCE with an empty FIFO is unreachable.

## Timing
- **Reset** (rst high at posedge): FIFO emptied, stale bits cleared, `cnt`=0, `state`=NORMAL.
- **While rst is asserted:** a_ready=0, b_ready=0, rf_wen=0, b_count=0; all inputs are ignored.
- **First cycle after rst deasserts:** a_ready=1, b_ready=1.
- **Reset mid-operation** drops all pending B writes; no partial write is issued.
- **Latency.**
  - A → rf write: 0 cycles. It is written at the same posedge it is accepted, so regfile internal bypass applies that cycle.
  - B → rf write: at least 1 cycle. A push at edge N can be written at edge N+1 at the earliest.
- **Worst-case B wait.** STARVE_LIMIT+1 cycles from reaching the head to being written.
- **Simultaneous events.** Pop and push in one cycle with b_count=2 cannot occur, because b_ready=0 then. With b_count=1, pop + push leaves b_count=1.
- **Ordering.** B writes to the register file in FIFO order. A and B never write in the same cycle.

## Test plan
- **A only.** Reset, then a_valid with r3←0x0042 for one cycle → same cycle rf_wen=1, rf_waddr=3, rf_wdata=0x0042; a_ready=1; b_count=0.
- **B only.** Push B r5←0x1111 at edge N, then idle → rf_wen=1, waddr=5, wdata=0x1111 in cycle N+1; b_count returns to 0 after edge N+1.
- **Starvation (STARVE_LIMIT=3).** Push B r7←0xBEEF, hold a_valid high continuously → A is granted 3 cycles; 4th cycle a_ready=0 and rf writes r7=0xBEEF; next cycle a_ready=1.
- **Squash.** Push B r2←0xAAAA; next cycle A r2←0x5555 is granted → r2 stays 0x5555; the head is discarded silently at the following edge with no write; b_count=0.
- **Full / back-pressure.** Push r1←1 and r4←4 while a_valid is held high → b_ready=0 at b_count=2. Drop a_valid → r1 then r4 written on consecutive cycles; b_ready returns to 1 once b_count<2.
- **Reset mid-operation.** b_count=2 and state FORCE, assert rst for 1 cycle → no rf_wen during or after; b_count=0; a_ready=b_ready=1 the next cycle.
